// File: rtl/quiz_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : quiz_timer_ctrl
// Purpose  : Game tick prescaler, elapsed-minutes counter and quiz scheduler
//            with an answer window; optional timeout via QUIZ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module quiz_timer_ctrl #(
  parameter int TICK_DIV     = 67108864,
  parameter int QUIZ_PERIOD  = 4,
  parameter int ANSWER_TICKS = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Clear,
  input  logic       Halt,
  input  logic       Ans_valid,
  input  logic       Ans_correct,
  output logic       tick,
  output logic [7:0] minutes,
  output logic       quiz_req,
  output logic       quiz_active,
  output logic [3:0] answer_left,
  output logic [3:0] quiz_cnt,
  output logic       life_dec,
  output logic       quiz_pass,
  output logic [1:0] state
);

  localparam int               c_PW   = $clog2(TICK_DIV);
  localparam logic [c_PW-1:0]  c_PMAX = c_PW'(TICK_DIV - 1);
  localparam logic [7:0]       c_IMAX = 8'(QUIZ_PERIOD - 1);
`ifdef QUIZ_TIMEOUT_EN
  localparam logic [3:0]       c_ANS_INIT = 4'(ANSWER_TICKS);
`else
  localparam logic [3:0]       c_ANS_INIT = 4'd0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_QUIZ = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_PW-1:0]   r_presc;
  logic [7:0]        r_interval;
  logic              w_wrap;

  assign w_wrap = (r_presc == c_PMAX);
  assign state  = r_state;

  always_ff @(posedge Clk) begin
    tick      <= 1'b0;
    quiz_req  <= 1'b0;
    life_dec  <= 1'b0;
    quiz_pass <= 1'b0;
    // Clear has the same effect as Reset, so both share the zeroing path.
    if (Reset || Clear) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_interval  <= '0;
      minutes     <= '0;
      quiz_active <= 1'b0;
      answer_left <= '0;
      quiz_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) r_state <= S_RUN;
        end
        S_RUN, S_QUIZ: begin
          if (Halt) begin
            r_state     <= S_HALT;
            quiz_active <= 1'b0;
          end else if (r_state == S_QUIZ && Ans_valid) begin
            quiz_pass   <= Ans_correct;
            life_dec    <= ~Ans_correct;
            r_state     <= S_RUN;
            quiz_active <= 1'b0;
            r_presc     <= '0;
            answer_left <= '0;
          end else if (w_wrap) begin
            r_presc <= '0;
            tick    <= 1'b1;
            if (r_state == S_RUN) begin
              minutes <= minutes + 8'd1;
              if (r_interval == c_IMAX) begin
                r_interval  <= '0;
                quiz_req    <= 1'b1;
                quiz_active <= 1'b1;
                r_state     <= S_QUIZ;
                answer_left <= c_ANS_INIT;
                if (quiz_cnt != 4'd15) quiz_cnt <= quiz_cnt + 4'd1;
              end else begin
                r_interval <= r_interval + 8'd1;
              end
            end else begin
`ifdef QUIZ_TIMEOUT_EN
              answer_left <= answer_left - 4'd1;
              if (answer_left == 4'd1) begin
                life_dec    <= 1'b1;
                r_state     <= S_RUN;
                quiz_active <= 1'b0;
              end
`endif
            end
          end else begin
            r_presc <= r_presc + c_PW'(1);
          end
        end
        default: begin
          // HALT: everything frozen until Clear or Reset.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quiz_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_quiz_timer_ctrl
// Purpose  : Scoreboard bench for quiz_timer_ctrl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quiz_timer_ctrl;
  localparam int TICK_DIV     = 4;
  localparam int QUIZ_PERIOD  = 3;
  localparam int ANSWER_TICKS = 2;
`ifdef QUIZ_TIMEOUT_EN
  localparam bit c_TO = 1'b1;
`else
  localparam bit c_TO = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, Start = 1'b0, Clear = 1'b0, Halt = 1'b0;
  logic       Ans_valid = 1'b0, Ans_correct = 1'b0;
  logic       tick, quiz_req, quiz_active, life_dec, quiz_pass;
  logic [7:0] minutes;
  logic [3:0] answer_left, quiz_cnt;
  logic [1:0] state;

  quiz_timer_ctrl #(
    .TICK_DIV(TICK_DIV), .QUIZ_PERIOD(QUIZ_PERIOD), .ANSWER_TICKS(ANSWER_TICKS)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Clear(Clear), .Halt(Halt),
    .Ans_valid(Ans_valid), .Ans_correct(Ans_correct), .tick(tick),
    .minutes(minutes), .quiz_req(quiz_req), .quiz_active(quiz_active),
    .answer_left(answer_left), .quiz_cnt(quiz_cnt), .life_dec(life_dec),
    .quiz_pass(quiz_pass), .state(state)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       tick;
    logic [7:0] minutes;
    logic       quiz_req;
    logic       quiz_active;
    logic [3:0] answer_left;
    logic [3:0] quiz_cnt;
    logic       life_dec;
    logic       quiz_pass;
    logic [1:0] state;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Model: game phase plus cycle age since the last prescaler restart, total
  // run ticks, run ticks since the last quiz, quizzes issued, answer ticks left.
  int m_state = 0, m_age = 0, m_total = 0, m_since = 0, m_quizzes = 0, m_left = 0;
  bit e_tick, e_req, e_life, e_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit rst, st, clr, hlt, av, ac);
    e_tick = 0; e_req = 0; e_life = 0; e_pass = 0;
    if (rst || clr) begin
      m_state = 0; m_age = 0; m_total = 0; m_since = 0; m_quizzes = 0; m_left = 0;
    end else if (m_state == 0) begin
      if (st) m_state = 1;
    end else if (m_state == 3) begin
      m_state = 3;
    end else if (hlt) begin
      m_state = 3;
    end else if (m_state == 2 && av) begin
      if (ac) e_pass = 1; else e_life = 1;
      m_state = 1; m_age = 0; m_left = 0;
    end else begin
      m_age++;
      if (m_age == TICK_DIV) begin
        m_age = 0;
        e_tick = 1;
        if (m_state == 1) begin
          m_total++;
          m_since++;
          if (m_since == QUIZ_PERIOD) begin
            m_since = 0; m_quizzes++; e_req = 1; m_state = 2;
            m_left = c_TO ? ANSWER_TICKS : 0;
          end
        end else if (c_TO) begin
          m_left--;
          if (m_left == 0) begin e_life = 1; m_state = 1; end
        end
      end
    end
  endtask

  task automatic step(input bit rst, st, clr, hlt, av, ac);
    out_t e;
    @(negedge Clk);
    Reset = rst; Start = st; Clear = clr; Halt = hlt; Ans_valid = av; Ans_correct = ac;
    @(posedge Clk);
    model_step(rst, st, clr, hlt, av, ac);
    e.tick        = e_tick;
    e.minutes     = 8'(m_total % 256);
    e.quiz_req    = e_req;
    e.quiz_active = (m_state == 2);
    e.answer_left = 4'(m_left);
    e.quiz_cnt    = 4'((m_quizzes > 15) ? 15 : m_quizzes);
    e.life_dec    = e_life;
    e.quiz_pass   = e_pass;
    e.state       = 2'(m_state);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      e = exp_q.pop_front();
      chk("sb_tick", 32'(tick), 32'(e.tick));
      chk("sb_minutes", 32'(minutes), 32'(e.minutes));
      chk("sb_quiz_req", 32'(quiz_req), 32'(e.quiz_req));
      chk("sb_quiz_active", 32'(quiz_active), 32'(e.quiz_active));
      chk("sb_answer_left", 32'(answer_left), 32'(e.answer_left));
      chk("sb_quiz_cnt", 32'(quiz_cnt), 32'(e.quiz_cnt));
      chk("sb_life_dec", 32'(life_dec), 32'(e.life_dec));
      chk("sb_quiz_pass", 32'(quiz_pass), 32'(e.quiz_pass));
      chk("sb_state", 32'(state), 32'(e.state));
    end
  end

  initial begin
    // Reset for two cycles, then one quiet cycle after release.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_minutes", 32'(minutes), 0);
    chk("rst_quiz_cnt", 32'(quiz_cnt), 0);
    chk("rst_pulses", {28'd0, tick, quiz_req, life_dec, quiz_pass}, 0);
    idle(1);
    chk("post_rst_pulses", {28'd0, tick, quiz_req, life_dec, quiz_pass}, 0);

    // First run: ticks every 4 cycles, quiz on the third tick.
    step(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      chk("run_tick", 32'(tick), (i % 4 == 0) ? 1 : 0);
    end
    chk("quiz_state", 32'(state), 2);
    chk("quiz_minutes", 32'(minutes), 3);
    chk("quiz_cnt1", 32'(quiz_cnt), 1);
    chk("quiz_req", 32'(quiz_req), 1);
    chk("quiz_answer_left", 32'(answer_left), c_TO ? 2 : 0);

    // Correct answer.
    step(0, 0, 0, 0, 1, 1);
    chk("pass_pulse", 32'(quiz_pass), 1);
    chk("pass_no_life", 32'(life_dec), 0);
    chk("pass_state", 32'(state), 1);
    chk("pass_minutes", 32'(minutes), 3);

    // Second quiz left unanswered.
    idle(12);
    chk("quiz2_state", 32'(state), 2);
    idle(4);
    chk("wait_answer_left", 32'(answer_left), c_TO ? 1 : 0);
    idle(4);
    chk("timeout_life", 32'(life_dec), c_TO ? 1 : 0);
    chk("timeout_state", 32'(state), c_TO ? 1 : 2);

    // Wrong answer landing on the would-be timeout edge.
    step(0, 0, 1, 0, 0, 0);
    chk("clear_state", 32'(state), 0);
    chk("clear_minutes", 32'(minutes), 0);
    step(0, 1, 0, 0, 0, 0);
    idle(12);
    idle(7);
    step(0, 0, 0, 0, 1, 0);
    chk("coinc_life", 32'(life_dec), 1);
    chk("coinc_state", 32'(state), 1);
    idle(1);
    chk("coinc_single_life", 32'(life_dec), 0);

    // Halt mid-quiz freezes; Start and Halt release are ignored; Clear exits.
    idle(12);
    idle(2);
    step(0, 0, 0, 1, 0, 0);
    chk("halt_state", 32'(state), 3);
    for (int i = 0; i < 10; i++) step(0, i % 2, 0, 0, i % 3 == 0, 1);
    chk("halt_frozen_state", 32'(state), 3);
    chk("halt_frozen_minutes", 32'(minutes), 6);
    chk("halt_frozen_cnt", 32'(quiz_cnt), 2);
    step(0, 0, 1, 0, 0, 0);
    chk("halt_clear_state", 32'(state), 0);
    chk("halt_clear_minutes", 32'(minutes), 0);

    // Long uninterrupted run: minutes wrap past 255 and quiz_cnt saturates.
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++)
      step(0, 0, 0, 0, $urandom_range(99) < 8, 1'($urandom));
    chk("long_quiz_cnt_sat", 32'(quiz_cnt), 15);

    // Fully random phase.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(999) < 3, $urandom_range(99) < 10, $urandom_range(99) < 2,
           $urandom_range(99) < 2, $urandom_range(99) < 15, 1'($urandom));

    idle(1);
    @(negedge Clk);
    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/quiz_timer_ctrl.md
QUIZ_TIMER_CTRL -- requirements
Module: quiz_timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 67108864: Clk cycles per game tick (>=2).
REQ-002 SHALL have parameter QUIZ_PERIOD, default 4: RUN ticks between quizzes (1..255).
REQ-003 SHALL have parameter ANSWER_TICKS, default 3: answer window in ticks (1..15).
REQ-004 SHALL have port Clk, input, 1: single system clock; all logic on rising edge.
REQ-005 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port Start, input, 1: one-cycle pulse; begins a run from IDLE.
REQ-007 SHALL have port Clear, input, 1: one-cycle pulse; abort to IDLE.
REQ-008 SHALL have port Halt, input, 1: level; game over (win/lose) freezes the block.
REQ-009 SHALL have port Ans_valid, input, 1: one-cycle pulse; student answer submitted.
REQ-010 SHALL have port Ans_correct, input, 1: qualifies Ans_valid; 1 = correct.
REQ-011 SHALL have port tick, output, 1: one-cycle pulse at each prescaler wrap.
REQ-012 SHALL have port minutes, output, 8: elapsed RUN ticks, paused during quiz.
REQ-013 SHALL have port quiz_req, output, 1: one-cycle pulse on QUIZ entry.
REQ-014 SHALL have port quiz_active, output, 1: high while in QUIZ.
REQ-015 SHALL have port answer_left, output, 4: remaining answer ticks.
REQ-016 SHALL have port quiz_cnt, output, 4: quizzes issued, saturating.
REQ-017 SHALL have port life_dec, output, 1: one-cycle pulse; wrong answer or timeout.
REQ-018 SHALL have port quiz_pass, output, 1: one-cycle pulse; correct answer.
REQ-019 SHALL have port state, output, 2: IDLE=0, RUN=1, QUIZ=2, HALT=3.

Function
REQ-020 SHALL implement FSM IDLE, RUN, QUIZ, HALT; all outputs registered.
REQ-021 IDLE SHALL hold prescaler, interval counter, minutes, answer_left, quiz_cnt at 0; Start -> RUN next cycle.
REQ-022 Prescaler SHALL count 0..TICK_DIV-1 in RUN and QUIZ only; tick SHALL pulse in the cycle after it reaches TICK_DIV-1 (first tick exactly TICK_DIV cycles after RUN/QUIZ entry).
REQ-023 In RUN, each tick SHALL increment minutes mod 256 (255 -> 0) and the interval counter.
REQ-024 The tick completing QUIZ_PERIOD RUN ticks SHALL also enter QUIZ: quiz_req pulse, quiz_cnt+1 (hold at 15), answer_left=ANSWER_TICKS, prescaler and interval counter zeroed.
REQ-025 In QUIZ, minutes SHALL NOT change; each tick SHALL decrement answer_left.
REQ-026 In QUIZ, Ans_valid with Ans_correct=1 SHALL pulse quiz_pass; with Ans_correct=0 SHALL pulse life_dec; either -> RUN next cycle, prescaler zeroed, answer_left=0.
REQ-027 Tick in QUIZ with answer_left=1 and no Ans_valid SHALL pulse life_dec and -> RUN (timeout).
REQ-028 Ans_valid coincident with timeout tick SHALL be treated as an answer only; exactly one of life_dec/quiz_pass per quiz.
REQ-029 Ans_valid outside QUIZ SHALL be ignored.
REQ-030 Halt=1 in RUN or QUIZ SHALL -> HALT next cycle; HALT freezes all counters, emits no pulses, ignores Start and Halt deassertion.
REQ-031 Clear SHALL -> IDLE next cycle from any state; priority Reset > Clear > Halt > Ans_valid > tick.
REQ-032 Start in RUN, QUIZ or HALT SHALL be ignored.

Reset
REQ-033 Reset=1 at a Clk edge SHALL force state=IDLE and all outputs and counters to 0, including mid-QUIZ.
REQ-034 No output SHALL pulse in the cycle following Reset deassertion.

Configuration
REQ-035 Macro QUIZ_TIMEOUT_EN defined: answer window per REQ-025/027.
REQ-036 QUIZ_TIMEOUT_EN undefined: QUIZ waits indefinitely for Ans_valid, answer_left held 0, tick still pulses, no timeout life_dec.

Verification (TICK_DIV=4, QUIZ_PERIOD=3, ANSWER_TICKS=2)
REQ-037 Reset 2 cycles -> state=0, minutes=0, quiz_cnt=0, all pulses 0.
REQ-038 Start, 12 cycles -> tick at cycles 4, 8, 12 of RUN; minutes=3; quiz_req at 3rd tick; state=2; quiz_cnt=1; answer_left=2.
REQ-039 In QUIZ, Ans_valid=1, Ans_correct=1 -> quiz_pass 1 cycle, state=1, minutes stays 3; life_dec never pulses.
REQ-040 In QUIZ, no answer 8 cycles -> answer_left 2->1, then single life_dec, state=1 (QUIZ_TIMEOUT_EN defined); undefined -> state stays 2.
REQ-041 Ans_valid, Ans_correct=0 on timeout cycle -> exactly one life_dec pulse; Halt mid-QUIZ -> state=3, frozen; Clear -> state=0, minutes=0.
REQ-042 Preload run to minutes=255, next RUN tick -> minutes=0; 16 quizzes -> quiz_cnt=15.
